// File: rtl/hilo_muldiv_unit.sv
// Iterative signed MULT/DIV engine plus the architectural HI/LO register pair.
// Optional single-cycle MULT when HILO_MULDIV_FAST_MULT_EN is defined.
// Ports: clk, reset (sync, active-high); start, aluControl, regHiLoWrite,
//   srcA, srcB in; busy, done, divByZero, hi, lo, hiLoOut out.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluControl,
  input  logic             regHiLoWrite,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hiLoOut
);

  localparam logic [3:0] ALU_MULT = 4'd8;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_MFHI = 4'd10;
  localparam logic [3:0] ALU_MFLO = 4'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_op;
  logic               r_signA;
  logic               r_signB;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_idle;
  logic               w_issue;
  logic               w_mul_go;
  logic               w_div_go;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_mul_in;
  logic [WIDTH-1:0]   w_mul_op;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_in;
  logic [WIDTH-1:0]   w_div_op;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_last;

  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = start && regHiLoWrite && w_idle;
  assign w_mul_go = w_issue && (aluControl == ALU_MULT);
  assign w_div_go = w_issue && (aluControl == ALU_DIV);
  assign w_absA   = srcA[WIDTH-1] ? -srcA : srcA;
  assign w_absB   = srcB[WIDTH-1] ? -srcB : srcB;
  assign w_last   = (r_cnt == CW'(1));

  // The issue edge already performs the first iteration on the fresh
  // magnitudes, so WIDTH steps fit in the issue edge plus WIDTH-1 busy cycles.
  assign w_mul_in = w_idle ? {{WIDTH{1'b0}}, w_absB} : r_acc;
  assign w_mul_op = w_idle ? w_absA : r_op;
  assign w_div_in = w_idle ? {{WIDTH{1'b0}}, w_absA} : r_acc;
  assign w_div_op = w_idle ? w_absB : r_op;

  // Shift-add: {upper, multiplier} shifts right, carry enters the top.
  assign w_sum = {1'b0, w_mul_in[2*WIDTH-1:WIDTH]}
               + (w_mul_in[0] ? {1'b0, w_mul_op} : '0);
  assign w_mul_next = {w_sum, w_mul_in[WIDTH-1:1]};

  // Restoring divide: {rem, quo} shifts left, quotient bit enters the bottom.
  assign w_shift = {w_div_in[2*WIDTH-1:WIDTH], w_div_in[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, w_div_op};
  assign w_ge    = ~w_trial[WIDTH];
  assign w_div_next = {(w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                       w_div_in[WIDTH-2:0], w_ge};

  assign w_prod = (r_signA ^ r_signB) ? -w_mul_next : w_mul_next;
  assign w_quo  = (r_signA ^ r_signB) ? -w_div_next[WIDTH-1:0]
                                      : w_div_next[WIDTH-1:0];
  assign w_rem  = r_signA ? -w_div_next[2*WIDTH-1:WIDTH]
                          : w_div_next[2*WIDTH-1:WIDTH];

`ifdef HILO_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] w_fast;
  // Low 2*WIDTH bits of the sign-extended product are the signed product.
  assign w_fast = {{WIDTH{srcA[WIDTH-1]}}, srcA}
                * {{WIDTH{srcB[WIDTH-1]}}, srcB};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_op    <= '0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mul_go) begin
`ifdef HILO_MULDIV_FAST_MULT_EN
            {r_hi, r_lo} <= w_fast;
            r_done       <= 1'b1;
`else
            r_state <= S_MUL;
            r_acc   <= w_mul_next;
            r_op    <= w_absA;
            r_signA <= srcA[WIDTH-1];
            r_signB <= srcB[WIDTH-1];
            r_cnt   <= CW'(WIDTH-1);
`endif
          end else if (w_div_go) begin
            if (srcB == '0) begin
              r_hi   <= srcA;
              r_lo   <= '1;
              r_done <= 1'b1;
              r_dbz  <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_acc   <= w_div_next;
              r_op    <= w_absB;
              r_signA <= srcA[WIDTH-1];
              r_signB <= srcB[WIDTH-1];
              r_cnt   <= CW'(WIDTH-1);
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          if (w_last) begin
            {r_hi, r_lo} <= w_prod;
            r_done       <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          if (w_last) begin
            r_hi    <= w_rem;
            r_lo    <= w_quo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    hiLoOut = '0;
    if (aluControl == ALU_MFHI) hiLoOut = r_hi;
    else if (aluControl == ALU_MFLO) hiLoOut = r_lo;
  end

  assign busy      = !w_idle;
  assign done      = r_done;
  assign divByZero = r_dbz;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: MULT/DIV timing, sign fix,
// divide by zero, HI/LO reads, ignored/back-to-back starts, reset abort.
module tb_hilo_muldiv_unit;

  localparam logic [3:0] ALU_MULT = 4'd8;
  localparam logic [3:0] ALU_DIV  = 4'd9;
  localparam logic [3:0] ALU_MFHI = 4'd10;
  localparam logic [3:0] ALU_MFLO = 4'd11;

`ifdef HILO_MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  aluControl;
  logic        regHiLoWrite;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hiLoOut;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .aluControl(aluControl), .regHiLoWrite(regHiLoWrite),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done),
    .divByZero(divByZero), .hi(hi), .lo(lo), .hiLoOut(hiLoOut)
  );

  // Drives one issue from the current negedge (cycle 0) and watches up to
  // 40 cycles; dcyc stays -1 if no done pulse appears.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int dcyc,
                        output int bcnt, output int blast,
                        output logic dbz);
    start = 1'b1; aluControl = op; regHiLoWrite = 1'b1;
    srcA = a; srcB = b;
    dcyc = -1; bcnt = 0; blast = 0; dbz = 1'b0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy) begin bcnt++; blast = c; end
      if (done) begin dcyc = c; dbz = divByZero; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; aluControl = 4'd0;
    regHiLoWrite = 1'b0; srcA = '0; srcB = '0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (divByZero !== 1'b0) begin n_bad++;
      $display("FAIL rst_dbz: got %b want 0", divByZero); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++;
      $display("FAIL rst_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++;
      $display("FAIL rst_lo: got %h want 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int d, bc, bl; logic z;
    run_op(ALU_MULT, 32'd7, 32'hFFFFFFFD, d, bc, bl, z);
    n_cmp++; if (d !== MUL_LAT) begin n_bad++;
      $display("FAIL mul_done_cyc: got %0d want %0d", d, MUL_LAT); end
    n_cmp++; if (bc !== MUL_LAT - 1) begin n_bad++;
      $display("FAIL mul_busy_cnt: got %0d want %0d", bc, MUL_LAT - 1); end
    n_cmp++; if (bl !== MUL_LAT - 1) begin n_bad++;
      $display("FAIL mul_busy_last: got %0d want %0d", bl, MUL_LAT - 1); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++;
      $display("FAIL mul_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++;
      $display("FAIL mul_lo: got %h want ffffffeb", lo); end
    n_cmp++; if (z !== 1'b0) begin n_bad++;
      $display("FAIL mul_dbz: got %b want 0", z); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL mul_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult_neg;
    int d, bc, bl; logic z;
    run_op(ALU_MULT, 32'hFFFFFFFC, 32'd5, d, bc, bl, z);
    n_cmp++; if (d !== MUL_LAT) begin n_bad++;
      $display("FAIL mul2_done_cyc: got %0d want %0d", d, MUL_LAT); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++;
      $display("FAIL mul2_hi: got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFEC) begin n_bad++;
      $display("FAIL mul2_lo: got %h want ffffffec", lo); end
  endtask

  task automatic test_div;
    int d, bc, bl; logic z;
    run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, d, bc, bl, z);
    n_cmp++; if (d !== 32) begin n_bad++;
      $display("FAIL div_done_cyc: got %0d want 32", d); end
    n_cmp++; if (bc !== 31) begin n_bad++;
      $display("FAIL div_busy_cnt: got %0d want 31", bc); end
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++;
      $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++;
      $display("FAIL div_hi: got %h want ffffffff", hi); end
    n_cmp++; if (z !== 1'b0) begin n_bad++;
      $display("FAIL div_dbz: got %b want 0", z); end
  endtask

  task automatic test_div_zero;
    int d, bc, bl; logic z;
    @(negedge clk);
    run_op(ALU_DIV, 32'd5, 32'd0, d, bc, bl, z);
    n_cmp++; if (d !== 1) begin n_bad++;
      $display("FAIL dz_done_cyc: got %0d want 1", d); end
    n_cmp++; if (bc !== 0) begin n_bad++;
      $display("FAIL dz_busy_cnt: got %0d want 0", bc); end
    n_cmp++; if (z !== 1'b1) begin n_bad++;
      $display("FAIL dz_flag: got %b want 1", z); end
    n_cmp++; if (hi !== 32'd5) begin n_bad++;
      $display("FAIL dz_hi: got %h want 5", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++;
      $display("FAIL dz_lo: got %h want ffffffff", lo); end
    @(negedge clk);
    n_cmp++; if (divByZero !== 1'b0) begin n_bad++;
      $display("FAIL dz_pulse: got %b want 0", divByZero); end
  endtask

  task automatic test_overflow_and_mf;
    int d, bc, bl; logic z;
    run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, d, bc, bl, z);
    n_cmp++; if (lo !== 32'h80000000) begin n_bad++;
      $display("FAIL ovf_lo: got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++;
      $display("FAIL ovf_hi: got %h want 0", hi); end
    aluControl = ALU_MFLO; #1;
    n_cmp++; if (hiLoOut !== 32'h80000000) begin n_bad++;
      $display("FAIL mflo_ovf: got %h want 80000000", hiLoOut); end
    @(negedge clk);
    run_op(ALU_MULT, 32'h00010000, 32'h00010000, d, bc, bl, z);
    n_cmp++; if (hi !== 32'd1) begin n_bad++;
      $display("FAIL big_hi: got %h want 1", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++;
      $display("FAIL big_lo: got %h want 0", lo); end
    aluControl = ALU_MFHI; #1;
    n_cmp++; if (hiLoOut !== 32'd1) begin n_bad++;
      $display("FAIL mfhi: got %h want 1", hiLoOut); end
    aluControl = ALU_MFLO; #1;
    n_cmp++; if (hiLoOut !== 32'd0) begin n_bad++;
      $display("FAIL mflo: got %h want 0", hiLoOut); end
    aluControl = 4'd0; #1;
    n_cmp++; if (hiLoOut !== 32'd0) begin n_bad++;
      $display("FAIL mf_other: got %h want 0", hiLoOut); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int d;
    start = 1'b1; aluControl = ALU_MULT; regHiLoWrite = 1'b1;
    srcA = 32'd6; srcB = 32'd7; d = -1;
    for (int c = 1; c <= 40 && d < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) d = c;
      if (c == 5) begin
        start = 1'b1; aluControl = ALU_DIV; srcA = 32'd9; srcB = 32'd3;
      end
    end
    n_cmp++; if (d !== MUL_LAT) begin n_bad++;
      $display("FAIL ign_done_cyc: got %0d want %0d", d, MUL_LAT); end
    n_cmp++; if (lo !== 32'd42) begin n_bad++;
      $display("FAIL ign_lo: got %h want 2a", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++;
      $display("FAIL ign_hi: got %h want 0", hi); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ign_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int d, bc, bl; logic z;
    run_op(ALU_MULT, 32'd3, 32'd4, d, bc, bl, z);
    n_cmp++; if (lo !== 32'd12) begin n_bad++;
      $display("FAIL b2b_mul_lo: got %h want c", lo); end
    run_op(ALU_DIV, 32'd100, 32'hFFFFFFF9, d, bc, bl, z);
    n_cmp++; if (d !== 32) begin n_bad++;
      $display("FAIL b2b_done_cyc: got %0d want 32", d); end
    n_cmp++; if (lo !== 32'hFFFFFFF2) begin n_bad++;
      $display("FAIL b2b_lo: got %h want fffffff2", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++;
      $display("FAIL b2b_hi: got %h want 2", hi); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    start = 1'b1; aluControl = ALU_DIV; regHiLoWrite = 1'b1;
    srcA = 32'd1000; srcB = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++;
      $display("FAIL rm_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0) begin n_bad++;
      $display("FAIL rm_lo: got %h want 0", lo); end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++; if (ndone !== 0) begin n_bad++;
      $display("FAIL rm_no_done: got %0d pulses want 0", ndone); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mult_neg;
    test_div;
    test_div_zero;
    test_overflow_and_mf;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
